// File: rtl/bundler_pkg.sv
// Shared types and constants for the multi-class majority bundler.
package bundler_pkg;

    // Tie resolution policy applied when a bit has exactly half the votes.
    typedef enum logic [1:0] {
        TIE_RANDOM = 2'd0,
        TIE_ZERO   = 2'd1,
        TIE_ONE    = 2'd2
    } tie_mode_e;

    // Controller states: accumulate, threshold one bank, present result.
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Feedback taps for x^32 + x^22 + x^2 + x + 1; bit k-1 marks term x^k.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/hdc_tie_gen.sv
// Tie-break source: 32-bit Fibonacci LFSR feeding a DIMENSIONS-bit shift
// register. Each step shifts the current LFSR msb into the tie vector.
module hdc_tie_gen
    import bundler_pkg::*;
#(
    parameter int          DIMENSIONS = 1024,
    parameter logic [31:0] LFSR_SEED  = 32'hee84d6f0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    output logic [DIMENSIONS-1:0] tie_vec
);

    // The seed is tiled across the whole vector so every bit starts defined.
    localparam int REPS = (DIMENSIONS + 31) / 32;
    localparam logic [REPS*32-1:0] SEED_TILED = {REPS{LFSR_SEED}};

    logic [31:0] lfsr;
    logic        feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    // Advance LFSR and tie vector together, once per step request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            tie_vec <= SEED_TILED[DIMENSIONS-1:0];
        end else if (step) begin
            lfsr    <= {lfsr[30:0], feedback};
            tie_vec <= {tie_vec[DIMENSIONS-2:0], lfsr[31]};
        end
    end

endmodule

// File: rtl/bundler_multiclass.sv
// Multi-class majority bundler: per-bit vote counters in NUM_CLASSES banks,
// thresholded on request into a bundled hypervector, then the bank is cleared.
// Optional feature macro: BUNDLER_OVF_EN (accept-and-drop on full bank with
// a sticky per-bank overflow flag reported as out_ovf).
module bundler_multiclass
    import bundler_pkg::*;
#(
    parameter int          DIMENSIONS  = 1024,
    parameter int          NUM_CLASSES = 2,
    parameter int          MAX_SAMPLES = 255,
    parameter logic [31:0] LFSR_SEED   = 32'hee84d6f0,
    parameter int          TIE_MODE    = 0,
    localparam int         COUNT_W     = $clog2(MAX_SAMPLES + 1),
    localparam int         CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CLASS_W-1:0]    in_class,
    input  logic [DIMENSIONS-1:0] hv_in,
    input  logic                  finish_valid,
    output logic                  finish_ready,
    input  logic [CLASS_W-1:0]    finish_class,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] hv_out,
    output logic [CLASS_W-1:0]    out_class,
`ifdef BUNDLER_OVF_EN
    output logic                  out_ovf,
`endif
    output logic [COUNT_W-1:0]    out_count
);

    state_e                state;
    logic [CLASS_W-1:0]    sel;
    logic [COUNT_W-1:0]    ctr [NUM_CLASSES][DIMENSIONS];
    logic [COUNT_W-1:0]    cnt [NUM_CLASSES];
    logic [DIMENSIONS-1:0] tie_vec;

    logic                  in_class_ok;
    logic                  in_bank_full;
    logic                  sample_fire;
    logic                  sample_take;
    logic                  sel_ok;
    logic [COUNT_W-1:0]    sel_cnt;
    logic [COUNT_W-1:0]    sel_ctr [DIMENSIONS];
    logic [DIMENSIONS-1:0] bundled;
`ifdef BUNDLER_OVF_EN
    logic [NUM_CLASSES-1:0] ovf;
    logic                   sel_ovf;
`endif

    // The tie vector read during EVAL is the current one; it advances afterwards.
    hdc_tie_gen #(
        .DIMENSIONS (DIMENSIONS),
        .LFSR_SEED  (LFSR_SEED)
    ) u_tie_gen (
        .clk     (clk),
        .rst     (rst),
        .step    (state == EVAL),
        .tie_vec (tie_vec)
    );

    // Look up the addressed input bank: is it a real bank, and is it full.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_class_ok  = 1'b0;
        in_bank_full = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (in_class == CLASS_W'(k)) begin
                in_class_ok  = 1'b1;
                in_bank_full = (cnt[k] >= COUNT_W'(MAX_SAMPLES));
            end
        end
    end

    assign finish_ready = (state == ACC);
`ifdef BUNDLER_OVF_EN
    assign in_ready = (state == ACC) && !finish_valid && in_class_ok;
`else
    assign in_ready = (state == ACC) && !finish_valid && in_class_ok && !in_bank_full;
`endif
    assign sample_fire = in_valid && in_ready;
    assign sample_take = sample_fire && !in_bank_full;

    // Select the bank being evaluated; out-of-range classes read as empty.
    always_comb begin
        sel_ok  = 1'b0;
        sel_cnt = '0;
`ifdef BUNDLER_OVF_EN
        sel_ovf = 1'b0;
`endif
        for (int i = 0; i < DIMENSIONS; i++) sel_ctr[i] = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (sel == CLASS_W'(k)) begin
                sel_ok  = 1'b1;
                sel_cnt = cnt[k];
`ifdef BUNDLER_OVF_EN
                sel_ovf = ovf[k];
`endif
                for (int i = 0; i < DIMENSIONS; i++) sel_ctr[i] = ctr[k][i];
            end
        end
    end

    // Majority threshold: compare 2c against n so odd/even n need no divide.
    always_comb begin
        bundled = '0;
        if (sel_ok) begin
            for (int i = 0; i < DIMENSIONS; i++) begin
                if ({sel_ctr[i], 1'b0} > {1'b0, sel_cnt}) begin
                    bundled[i] = 1'b1;
                end else if ({sel_ctr[i], 1'b0} == {1'b0, sel_cnt}) begin
                    case (TIE_MODE)
                        int'(TIE_ZERO): bundled[i] = 1'b0;
                        int'(TIE_ONE):  bundled[i] = 1'b1;
                        default:        bundled[i] = tie_vec[i];
                    endcase
                end
            end
        end
    end

    // Controller, vote accumulation, bank clearing and registered result.
    // NOTE: state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            sel       <= '0;
            out_valid <= 1'b0;
            hv_out    <= '0;
            out_class <= '0;
            out_count <= '0;
`ifdef BUNDLER_OVF_EN
            ovf       <= '0;
            out_ovf   <= 1'b0;
`endif
            // NOTE: the counter arrays are reset because a bank must read empty after reset.
            for (int k = 0; k < NUM_CLASSES; k++) begin
                cnt[k] <= '0;
                for (int i = 0; i < DIMENSIONS; i++) ctr[k][i] <= '0;
            end
        end else begin
            case (state)
                ACC: begin
                    if (finish_valid) begin
                        sel   <= finish_class;
                        state <= EVAL;
                    end
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        if (in_class == CLASS_W'(k)) begin
                            if (sample_take) begin
                                cnt[k] <= cnt[k] + 1'b1;
                                for (int i = 0; i < DIMENSIONS; i++)
                                    ctr[k][i] <= ctr[k][i] + COUNT_W'(hv_in[i]);
                            end
`ifdef BUNDLER_OVF_EN
                            if (sample_fire && in_bank_full) ovf[k] <= 1'b1;
`endif
                        end
                    end
                end
                EVAL: begin
                    hv_out    <= bundled;
                    out_count <= sel_cnt;
                    out_class <= sel;
                    out_valid <= 1'b1;
                    state     <= HOLD;
`ifdef BUNDLER_OVF_EN
                    out_ovf   <= sel_ovf;
`endif
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        if (sel == CLASS_W'(k)) begin
                            cnt[k] <= '0;
                            for (int i = 0; i < DIMENSIONS; i++) ctr[k][i] <= '0;
`ifdef BUNDLER_OVF_EN
                            ovf[k] <= 1'b0;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_bundler_multiclass.sv
// Directed bench for bundler_multiclass: DIMENSIONS=8, two banks, three
// samples per bank. Two instances share stimulus: dut_a forces ties to 0,
// dut_b resolves ties from the LFSR tie vector.
module tb_bundler_multiclass;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_class = 1'b0;
    logic [7:0] hv_in = 8'h00;
    logic       finish_valid = 1'b0;
    logic       finish_class = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, finish_ready_a, out_valid_a, out_class_a;
    logic [7:0] hv_out_a;
    logic [1:0] out_count_a;
    logic       in_ready_b, finish_ready_b, out_valid_b, out_class_b;
    logic [7:0] hv_out_b;
    logic [1:0] out_count_b;
`ifdef BUNDLER_OVF_EN
    logic       out_ovf_a, out_ovf_b;
    localparam logic FULL_RDY = 1'b1;
    localparam logic FULL_OVF = 1'b1;
    logic       ovf_seen;
`else
    localparam logic FULL_RDY = 1'b0;
    localparam logic FULL_OVF = 1'b0;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] b_hv;
    logic [7:0] b_first;

    always #5 clk = ~clk;

    bundler_multiclass #(
        .DIMENSIONS(8), .NUM_CLASSES(2), .MAX_SAMPLES(3),
        .LFSR_SEED(32'hee84d6f0), .TIE_MODE(1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_class(in_class), .hv_in(hv_in),
        .finish_valid(finish_valid), .finish_ready(finish_ready_a), .finish_class(finish_class),
        .out_valid(out_valid_a), .out_ready(out_ready), .hv_out(hv_out_a),
        .out_class(out_class_a),
`ifdef BUNDLER_OVF_EN
        .out_ovf(out_ovf_a),
`endif
        .out_count(out_count_a)
    );

    bundler_multiclass #(
        .DIMENSIONS(8), .NUM_CLASSES(2), .MAX_SAMPLES(3),
        .LFSR_SEED(32'hee84d6f0), .TIE_MODE(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_class(in_class), .hv_in(hv_in),
        .finish_valid(finish_valid), .finish_ready(finish_ready_b), .finish_class(finish_class),
        .out_valid(out_valid_b), .out_ready(out_ready), .hv_out(hv_out_b),
        .out_class(out_class_b),
`ifdef BUNDLER_OVF_EN
        .out_ovf(out_ovf_b),
`endif
        .out_count(out_count_b)
    );

    typedef struct {
        bit         is_fin;
        logic       cls;
        logic [7:0] hv;
        logic       exp_rdy;
        logic [7:0] exp_hv;
        logic [1:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_sample(input logic cls, input logic [7:0] hv, input logic exp_rdy,
                             input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_class = cls;
        hv_in    = hv;
        #1 check({tag, ".in_ready"}, 32'(in_ready_a), 32'(exp_rdy));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Finish request, exact two-cycle latency check, result check, handshake.
    task automatic do_finish(input logic cls, input logic [7:0] exp_hv, input logic [1:0] exp_cnt,
                             input bit with_sample, input string tag);
        @(negedge clk);
        finish_valid = 1'b1;
        finish_class = cls;
        if (with_sample) begin
            in_valid = 1'b1;
            in_class = cls;
            hv_in    = 8'hFF;
        end
        #1 check({tag, ".finish_ready"}, 32'(finish_ready_a), 32'd1);
        if (with_sample) check({tag, ".in_ready_prio"}, 32'(in_ready_a), 32'd0);
        @(posedge clk);
        #1 begin
            finish_valid = 1'b0;
            in_valid     = 1'b0;
        end
        @(negedge clk);
        #1 check({tag, ".valid_n1"}, 32'(out_valid_a), 32'd0);
        @(negedge clk);
        #1 begin
            check({tag, ".valid_n2"}, 32'(out_valid_a), 32'd1);
            check({tag, ".hv_out"}, 32'(hv_out_a), 32'(exp_hv));
            check({tag, ".out_count"}, 32'(out_count_a), 32'(exp_cnt));
            check({tag, ".out_class"}, 32'(out_class_a), 32'(cls));
            b_hv = hv_out_b;
`ifdef BUNDLER_OVF_EN
            ovf_seen = out_ovf_a;
`endif
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        #1 check({tag, ".valid_drop"}, 32'(out_valid_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //            fin   cls   hv     rdy       exp_hv  cnt   ovf
        vecs[0]  = '{1'b0, 1'b0, 8'hF0, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'hCC, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'hAA, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h55, FULL_RDY, 8'h00, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1,     8'hE8, 2'd3, FULL_OVF};
        vecs[5]  = '{1'b0, 1'b1, 8'hFF, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h0F, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1,     8'h00, 2'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b1,     8'h00, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1,     8'h0F, 2'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b1,     8'h00, 2'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        #1 begin
            check("rst.out_valid", 32'(out_valid_a), 32'd0);
            check("rst.hv_out", 32'(hv_out_a), 32'd0);
            check("rst.out_count", 32'(out_count_a), 32'd0);
            check("rst.out_class", 32'(out_class_a), 32'd0);
            check("rst.in_ready", 32'(in_ready_a), 32'd1);
            check("rst.finish_ready", 32'(finish_ready_a), 32'd1);
        end

        // Table-driven majority, interleaving and bank-full vectors.
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].is_fin) begin
                do_finish(vecs[v].cls, vecs[v].exp_hv, vecs[v].exp_cnt, 1'b0,
                          $sformatf("v%0d", v));
`ifdef BUNDLER_OVF_EN
                check($sformatf("v%0d.out_ovf", v), 32'(ovf_seen), 32'(vecs[v].exp_ovf));
`endif
            end else begin
                do_sample(vecs[v].cls, vecs[v].hv, vecs[v].exp_rdy, $sformatf("v%0d", v));
            end
        end

        // Same-cycle finish and sample: finish wins, sample not counted.
        do_finish(1'b0, 8'h00, 2'd0, 1'b1, "prio");

        // Backpressure: result held 5 cycles with both inputs requesting.
        do_sample(1'b1, 8'hFF, 1'b1, "bp.load");
        @(negedge clk);
        finish_valid = 1'b1;
        finish_class = 1'b1;
        @(posedge clk);
        #1 finish_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid     = 1'b1;
        in_class     = 1'b0;
        hv_in        = 8'hFF;
        finish_valid = 1'b1;
        finish_class = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 begin
                check($sformatf("bp%0d.out_valid", c), 32'(out_valid_a), 32'd1);
                check($sformatf("bp%0d.hv_out", c), 32'(hv_out_a), 32'hFF);
                check($sformatf("bp%0d.in_ready", c), 32'(in_ready_a), 32'd0);
                check($sformatf("bp%0d.finish_ready", c), 32'(finish_ready_a), 32'd0);
            end
            @(negedge clk);
        end
        in_valid     = 1'b0;
        finish_valid = 1'b0;
        out_ready    = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        do_finish(1'b0, 8'h00, 2'd0, 1'b0, "bp.after");

        // Reset while holding a result discards it and all bank contents.
        do_sample(1'b0, 8'hF0, 1'b1, "rh.s0");
        do_sample(1'b1, 8'h0F, 1'b1, "rh.s1");
        @(negedge clk);
        finish_valid = 1'b1;
        finish_class = 1'b0;
        @(posedge clk);
        #1 finish_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("rh.hold_valid", 32'(out_valid_a), 32'd1);
        do_reset();
        @(negedge clk);
        #1 begin
            check("rh.out_valid", 32'(out_valid_a), 32'd0);
            check("rh.hv_out", 32'(hv_out_a), 32'd0);
            check("rh.out_count", 32'(out_count_a), 32'd0);
            check("rh.finish_ready", 32'(finish_ready_a), 32'd1);
        end
        do_finish(1'b1, 8'h00, 2'd0, 1'b0, "rh.bank1");

        // Random ties on empty banks: seed low byte, then shifted vectors.
        do_reset();
        do_finish(1'b0, 8'h00, 2'd0, 1'b0, "rnd1");
        b_first = b_hv;
        check("rnd1.b_hv", 32'(b_hv), 32'hF0);
        do_finish(1'b1, 8'h00, 2'd0, 1'b0, "rnd2");
        check("rnd2.b_hv", 32'(b_hv), 32'hE1);
        check("rnd2.differs", 32'(b_hv != b_first), 32'd1);
        do_finish(1'b0, 8'h00, 2'd0, 1'b0, "rnd3");
        check("rnd3.b_hv", 32'(b_hv), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
